// File: rtl/vga_pkg.sv
// Shared video-path definitions: default 640x480@60 raster timing, counter width
// and the 3-3-2 pixel type used by the layer generators and the mixer.
package vga_pkg;

  localparam int CNT_W = 10;

  localparam int H_ACTIVE_D = 640;
  localparam int H_FP_D     = 16;
  localparam int H_SYNC_D   = 96;
  localparam int H_BP_D     = 48;
  localparam int V_ACTIVE_D = 480;
  localparam int V_FP_D     = 10;
  localparam int V_SYNC_D   = 2;
  localparam int V_BP_D     = 33;

  function automatic int timing_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  localparam int H_TOTAL_D = timing_total(H_ACTIVE_D, H_FP_D, H_SYNC_D, H_BP_D);
  localparam int V_TOTAL_D = timing_total(V_ACTIVE_D, V_FP_D, V_SYNC_D, V_BP_D);

  typedef logic [CNT_W-1:0] count_t;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb332_t;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster bundle between the timing generator (master) and its consumers (slave).
interface vga_timing_gen_if;
  import vga_pkg::*;

  logic   pix_ce;
  count_t hcount;
  count_t vcount;
  logic   enable;
  logic   line_start;
  logic   frame_start;
  logic   hsync;
  logic   vsync;
  logic   blank;

  modport master (
    input  pix_ce,
    output hcount, vcount, enable, line_start, frame_start, hsync, vsync, blank
  );

  modport slave (
    output pix_ce,
    input  hcount, vcount, enable, line_start, frame_start, hsync, vsync, blank
  );

endinterface

// File: rtl/sync_delay_line.sv
// Clock-enabled shift register that lines sync/blank up with registered layer RGB.
// Depth 0 is a pure wire; every stage resets to its own idle value.
module sync_delay_line #(
  parameter int                DEPTH     = 1,
  parameter int                WIDTH     = 3,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ce,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_bypass
    logic unused_ctrl;
    assign unused_ctrl = clock ^ reset ^ ce;
    assign dout = din;
  end else begin : g_pipe
    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clock) begin
      if (reset) begin
        for (int i = 0; i < DEPTH; i++) stage[i] <= RESET_VAL;
      end else if (ce) begin
        stage[0] <= din;
        for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
    end

    assign dout = stage[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster counters plus sync/blank generation for the video path; sync and blank
// are delayed PIPE_DELAY enabled pixels to match the layers' registered RGB.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = H_ACTIVE_D,
  parameter int H_FP       = H_FP_D,
  parameter int H_SYNC     = H_SYNC_D,
  parameter int H_BP       = H_BP_D,
  parameter int V_ACTIVE   = V_ACTIVE_D,
  parameter int V_FP       = V_FP_D,
  parameter int V_SYNC     = V_SYNC_D,
  parameter int V_BP       = V_BP_D,
  parameter bit HSYNC_POL  = 1'b0,
  parameter bit VSYNC_POL  = 1'b0,
  parameter int PIPE_DELAY = 1
) (
  input logic             clock,
  input logic             reset,
  vga_timing_gen_if.master vid
);

  localparam int H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_total_check
    $error("vga_timing_gen: raster totals do not fit the counter width");
  end
  if (PIPE_DELAY < 0 || PIPE_DELAY > 4) begin : g_delay_check
    $error("vga_timing_gen: PIPE_DELAY must be 0..4");
  end

  localparam count_t H_LAST   = count_t'(H_TOTAL - 1);
  localparam count_t V_LAST   = count_t'(V_TOTAL - 1);
  localparam count_t H_ACT_C  = count_t'(H_ACTIVE);
  localparam count_t V_ACT_C  = count_t'(V_ACTIVE);
  localparam count_t H_SS     = count_t'(H_ACTIVE + H_FP);
  localparam count_t H_SE     = count_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam count_t V_SS     = count_t'(V_ACTIVE + V_FP);
  localparam count_t V_SE     = count_t'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [2:0] SYNC_IDLE = {~HSYNC_POL, ~VSYNC_POL, 1'b1};

  count_t     hcount;
  count_t     vcount;
  logic       enable_raw;
  logic       hsync_raw;
  logic       vsync_raw;
  logic [2:0] sync_out;

  // Reset wins over pix_ce so a mid-frame reset always lands on pixel (0,0).
  always_ff @(posedge clock) begin
    if (reset) begin
      hcount <= '0;
      vcount <= '0;
    end else if (vid.pix_ce) begin
      if (hcount == H_LAST) begin
        hcount <= '0;
        vcount <= (vcount == V_LAST) ? '0 : vcount + 1'b1;
      end else begin
        hcount <= hcount + 1'b1;
      end
    end
  end

  assign enable_raw = (hcount < H_ACT_C) && (vcount < V_ACT_C);
  assign hsync_raw  = ((hcount >= H_SS) && (hcount < H_SE)) ? HSYNC_POL : ~HSYNC_POL;
  assign vsync_raw  = ((vcount >= V_SS) && (vcount < V_SE)) ? VSYNC_POL : ~VSYNC_POL;

  sync_delay_line #(
    .DEPTH     (PIPE_DELAY),
    .WIDTH     (3),
    .RESET_VAL (SYNC_IDLE)
  ) u_sync_delay (
    .clock (clock),
    .reset (reset),
    .ce    (vid.pix_ce),
    .din   ({hsync_raw, vsync_raw, ~enable_raw}),
    .dout  (sync_out)
  );

  assign vid.hcount      = hcount;
  assign vid.vcount      = vcount;
  assign vid.enable      = enable_raw;
  assign vid.line_start  = vid.pix_ce & (hcount == '0);
  assign vid.frame_start = vid.pix_ce & (hcount == '0) & (vcount == '0);
  assign vid.hsync       = sync_out[2];
  assign vid.vsync       = sync_out[1];
  assign vid.blank       = sync_out[0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default-timing instance for line-level checks and a shrunken
// raster instance (24x10, positive hsync) so whole frames fit in a short run.
module tb_vga_timing_gen;
  import vga_pkg::*;

  logic clock = 1'b0;
  logic reset;
  logic pixCe;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  bit   countOn = 0;
  int   lsCountA = 0;
  int   lsCountB = 0;
  int   fsCountB = 0;

  typedef struct {
    int sel, cyc, h, v, en, ls, fs, hs, vs, bl;
  } vec_t;
  vec_t vecs[$];

  vga_timing_gen_if ifA ();
  vga_timing_gen_if ifB ();
  assign ifA.pix_ce = pixCe;
  assign ifB.pix_ce = pixCe;

  vga_timing_gen dutA (.clock(clock), .reset(reset), .vid(ifA));

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b0), .PIPE_DELAY(1)
  ) dutB (.clock(clock), .reset(reset), .vid(ifB));

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic stepClock();
    @(posedge clock);
    #1;
    if (pixCe && !reset) cyc++;
    if (countOn && cyc >= 1 && cyc <= 800) lsCountA += int'(ifA.line_start);
    if (countOn && cyc >= 1 && cyc <= 240) begin
      lsCountB += int'(ifB.line_start);
      fsCountB += int'(ifB.frame_start);
    end
  endtask

  task automatic applyStimulus(input int target);
    pixCe = 1'b1;
    while (cyc < target) stepClock();
  endtask

  function automatic void addVec(input int sel, input int c, input int h, input int v,
                                 input int en, input int ls, input int fs,
                                 input int hs, input int vs, input int bl);
    vec_t t;
    t = '{sel, c, h, v, en, ls, fs, hs, vs, bl};
    vecs.push_back(t);
  endfunction

  initial begin
    int prevH, prevHs, expH, holdViol, modelViol, hsLow;

    // sel 0 = default raster (800 wide), sel 1 = 24x10 raster; cyc = enabled edges since reset release
    addVec(0,   1,   1, 0, 1, 0, 0, 1, 1, 0);
    addVec(1, 135,  15, 5, 1, 0, 0, 0, 1, 0);
    addVec(1, 136,  16, 5, 0, 0, 0, 0, 1, 0);
    addVec(1, 137,  17, 5, 0, 0, 0, 0, 1, 1);
    addVec(1, 138,  18, 5, 0, 0, 0, 0, 1, 1);
    addVec(1, 139,  19, 5, 0, 0, 0, 1, 1, 1);
    addVec(1, 142,  22, 5, 0, 0, 0, 1, 1, 1);
    addVec(1, 143,  23, 5, 0, 0, 0, 0, 1, 1);
    addVec(1, 144,   0, 6, 0, 1, 0, 0, 1, 1);
    addVec(1, 168,   0, 7, 0, 1, 0, 0, 1, 1);
    addVec(1, 169,   1, 7, 0, 0, 0, 0, 0, 1);
    addVec(1, 216,   0, 9, 0, 1, 0, 0, 0, 1);
    addVec(1, 217,   1, 9, 0, 0, 0, 0, 1, 1);
    addVec(1, 239,  23, 9, 0, 0, 0, 0, 1, 1);
    addVec(1, 240,   0, 0, 1, 1, 1, 0, 1, 1);
    addVec(1, 241,   1, 0, 1, 0, 0, 0, 1, 0);
    addVec(0, 639, 639, 0, 1, 0, 0, 1, 1, 0);
    addVec(0, 640, 640, 0, 0, 0, 0, 1, 1, 0);
    addVec(0, 641, 641, 0, 0, 0, 0, 1, 1, 1);
    addVec(0, 656, 656, 0, 0, 0, 0, 1, 1, 1);
    addVec(0, 657, 657, 0, 0, 0, 0, 0, 1, 1);
    addVec(0, 751, 751, 0, 0, 0, 0, 0, 1, 1);
    addVec(0, 752, 752, 0, 0, 0, 0, 0, 1, 1);
    addVec(0, 753, 753, 0, 0, 0, 0, 1, 1, 1);
    addVec(0, 799, 799, 0, 0, 0, 0, 1, 1, 1);
    addVec(0, 800,   0, 1, 1, 1, 0, 1, 1, 1);
    addVec(0, 801,   1, 1, 1, 0, 0, 1, 1, 0);

    reset = 1'b1;
    pixCe = 1'b1;
    repeat (3) stepClock();
    checkOutput("rst_hcount", int'(ifA.hcount), 0);
    checkOutput("rst_vcount", int'(ifA.vcount), 0);
    checkOutput("rst_enable", int'(ifA.enable), 1);
    checkOutput("rst_hsync",  int'(ifA.hsync), 1);
    checkOutput("rst_vsync",  int'(ifA.vsync), 1);
    checkOutput("rst_blank",  int'(ifA.blank), 1);
    checkOutput("rstB_hsync", int'(ifB.hsync), 0);
    checkOutput("rstB_blank", int'(ifB.blank), 1);

    reset = 1'b0;
    cyc = 0;
    countOn = 1;
    #1;
    checkOutput("rel_frame_start", int'(ifA.frame_start), 1);
    checkOutput("rel_line_start",  int'(ifA.line_start), 1);
    checkOutput("rel_blank",       int'(ifA.blank), 1);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].cyc);
      if (vecs[i].sel == 0) begin
        checkOutput($sformatf("v%0d_hcount", i), int'(ifA.hcount), vecs[i].h);
        checkOutput($sformatf("v%0d_vcount", i), int'(ifA.vcount), vecs[i].v);
        checkOutput($sformatf("v%0d_enable", i), int'(ifA.enable), vecs[i].en);
        checkOutput($sformatf("v%0d_line_start", i), int'(ifA.line_start), vecs[i].ls);
        checkOutput($sformatf("v%0d_frame_start", i), int'(ifA.frame_start), vecs[i].fs);
        checkOutput($sformatf("v%0d_hsync", i), int'(ifA.hsync), vecs[i].hs);
        checkOutput($sformatf("v%0d_vsync", i), int'(ifA.vsync), vecs[i].vs);
        checkOutput($sformatf("v%0d_blank", i), int'(ifA.blank), vecs[i].bl);
      end else begin
        checkOutput($sformatf("v%0d_hcount", i), int'(ifB.hcount), vecs[i].h);
        checkOutput($sformatf("v%0d_vcount", i), int'(ifB.vcount), vecs[i].v);
        checkOutput($sformatf("v%0d_enable", i), int'(ifB.enable), vecs[i].en);
        checkOutput($sformatf("v%0d_line_start", i), int'(ifB.line_start), vecs[i].ls);
        checkOutput($sformatf("v%0d_frame_start", i), int'(ifB.frame_start), vecs[i].fs);
        checkOutput($sformatf("v%0d_hsync", i), int'(ifB.hsync), vecs[i].hs);
        checkOutput($sformatf("v%0d_vsync", i), int'(ifB.vsync), vecs[i].vs);
        checkOutput($sformatf("v%0d_blank", i), int'(ifB.blank), vecs[i].bl);
      end
    end
    countOn = 0;
    checkOutput("lineA_pulses_800",  lsCountA, 1);
    checkOutput("lineB_pulses_frame", lsCountB, 10);
    checkOutput("frameB_pulses",     fsCountB, 1);

    // Alternate pix_ce: nothing may move on a disabled edge, hsync width doubles in clocks
    expH = 1;
    holdViol = 0;
    modelViol = 0;
    hsLow = 0;
    for (int k = 0; k < 1520; k++) begin
      pixCe = (k % 2 == 0);
      prevH = int'(ifA.hcount);
      prevHs = int'(ifA.hsync);
      stepClock();
      if (pixCe) expH = (expH + 1) % 800;
      else if (int'(ifA.hcount) != prevH || int'(ifA.hsync) != prevHs) holdViol++;
      if (int'(ifA.hcount) != expH) modelViol++;
      if (ifA.hsync == 1'b0) hsLow++;
    end
    checkOutput("toggle_hold_violations", holdViol, 0);
    checkOutput("toggle_hcount_model", modelViol, 0);
    checkOutput("toggle_hsync_low_clocks", hsLow, 192);
    checkOutput("toggle_final_hcount", int'(ifA.hcount), 761);
    checkOutput("toggle_final_vcount", int'(ifA.vcount), 1);

    // Reset in the middle of an hsync pulse with pix_ce low
    applyStimulus(2300);
    checkOutput("mid_pre_hcount", int'(ifA.hcount), 700);
    checkOutput("mid_pre_hsync",  int'(ifA.hsync), 0);
    reset = 1'b1;
    pixCe = 1'b0;
    stepClock();
    checkOutput("mid_rst_hcount", int'(ifA.hcount), 0);
    checkOutput("mid_rst_vcount", int'(ifA.vcount), 0);
    checkOutput("mid_rst_hsync",  int'(ifA.hsync), 1);
    checkOutput("mid_rst_vsync",  int'(ifA.vsync), 1);
    checkOutput("mid_rst_blank",  int'(ifA.blank), 1);
    checkOutput("mid_rstB_hcount", int'(ifB.hcount), 0);
    checkOutput("mid_rstB_hsync",  int'(ifB.hsync), 0);
    reset = 1'b0;
    pixCe = 1'b1;
    cyc = 0;
    #1;
    checkOutput("mid_rel_frame_start", int'(ifA.frame_start), 1);
    applyStimulus(656);
    checkOutput("resume_hsync_656", int'(ifA.hsync), 1);
    checkOutput("resume_hcount_656", int'(ifA.hcount), 656);
    applyStimulus(657);
    checkOutput("resume_hsync_657", int'(ifA.hsync), 0);
    checkOutput("resume_vcount", int'(ifA.vcount), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates the raster scan that drives every layer generator in the video path: hcount, vcount and the active-area enable.
- Produces VGA hsync, vsync and blank, delayed by a configurable pipeline depth so they align with the registered RGB that the layers emit one clock after they sample the counters.
- Sits directly upstream of the background, sprite and overlay layers, and feeds the output pins alongside the layer mixer.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch in pixels
- H_SYNC, 96, hsync pulse width in pixels
- H_BP, 48, horizontal back porch in pixels
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch in lines
- V_SYNC, 2, vsync pulse width in lines
- V_BP, 33, vertical back porch in lines
- HSYNC_POL, 0, asserted level of hsync (0 = active-low)
- VSYNC_POL, 0, asserted level of vsync
- PIPE_DELAY, 1, clocks of delay on hsync/vsync/blank; legal range 0..4

Ports:
- clock  in  1  system/pixel clock
- reset  in  1  synchronous, active-high reset
- pix_ce  in  1  pixel clock enable; tie to 1 when clock is the pixel clock
- hcount  out  10  current pixel column, 0..H_TOTAL-1
- vcount  out  10  current line, 0..V_TOTAL-1
- enable  out  1  high when hcount < H_ACTIVE and vcount < V_ACTIVE
- line_start  out  1  one-cycle pulse at the start of each line
- frame_start  out  1  one-cycle pulse at the start of each frame
- hsync  out  1  delayed horizontal sync to the connector
- vsync  out  1  delayed vertical sync to the connector
- blank  out  1  delayed inverse of enable; the mixer forces black when high

Behaviour:
- Clock and reset: one clock domain. Reset is synchronous and active-high; reset is sampled only on the rising edge of clock.
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525).
- Counters are registered.
- On a rising edge with pix_ce=1:
  - hcount increments.
  - At H_TOTAL-1, hcount wraps to 0 and vcount increments.
  - When hcount=H_TOTAL-1 and vcount=V_TOTAL-1, both wrap to 0 on the same edge.
- With pix_ce=0, every register holds, including the delay line.
- enable is a combinational decode of the registered counters. It is valid in the same cycle as hcount/vcount, so a layer registering RGB on the next edge is one clock behind.
- line_start = pix_ce & (hcount==0).
- frame_start = pix_ce & (hcount==0) & (vcount==0).
- Raw hsync is asserted while H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC (656..751).
- Raw vsync is asserted while V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC (490..491). Vsync changes on the pixel-0 boundary of a line.
- Raw blank = ~enable.
- Delay line:
  - {hsync, vsync, blank} pass through a PIPE_DELAY-deep shift register advanced by pix_ce.
  - PIPE_DELAY=0 is a combinational bypass.
- Reset values:
  - hcount=0, vcount=0.
  - Every delay stage loads the deasserted level: hsync=~HSYNC_POL, vsync=~VSYNC_POL, blank=1.
  - enable=1 (decoded from 0,0).
- frame_start and line_start assert on the first pix_ce cycle after reset is released.
- Reset mid-frame: counters return to 0,0 on the next edge regardless of pix_ce. The delay line is flushed to deasserted values; no partial sync pulse is extended.
- Reset takes priority over pix_ce.
- Widths: 10-bit counters. Elaboration fails if H_TOTAL or V_TOTAL > 1024, or if PIPE_DELAY > 4.

Decomposition:
- Shared package vga_pkg holds:
  - the default 640x480@60 timing constants;
  - H_TOTAL and V_TOTAL derivation;
  - the counter width constant (10);
  - a 3-3-2 RGB pixel typedef reused by the layer generators and the mixer.
- One natural sub-module, sync_delay_line: parameterised depth, width 3, per-bit reset value, advanced by pix_ce.

Test Plan:
- Reset release with pix_ce=1 -> hcount=0, vcount=0, frame_start=1 in the first cycle; hsync=1, vsync=1, blank=1 for PIPE_DELAY cycles.
- Run 800 pix_ce cycles -> hcount reaches 799 then 0; vcount steps 0->1 on the same edge; line_start pulses exactly once per 800 cycles.
- Full frame -> raw hsync low for hcount 656..751, observed on the hsync pin one clock later. vsync low exactly while vcount=490..491. Frame period is 420000 cycles, and frame_start pulses once.
- Active edges -> enable=1 at (639,479) and enable=0 at (640,479) and (0,480). blank goes to 1 one clock after enable falls.
- Toggle pix_ce 1/0 alternately -> counters advance only on pix_ce=1 cycles; hsync pulse width is 96 enabled cycles (192 clocks); no sync edge occurs on a pix_ce=0 cycle.
- Assert reset at (700,300) while hsync is low -> next edge gives hcount=0, vcount=0, hsync=1, vsync=1, blank=1. Normal timing resumes with the first hsync low at hcount=656 of line 0.
